// File: rtl/femto_mem_arbiter.sv
// Two-master round-robin arbiter for the PicoRV32 native memory bus.
// The grant is held for a whole transfer, and a per-transfer timeout completes requests that a hung slave never acknowledges.
module femto_mem_arbiter #(
  parameter int unsigned TIMEOUT   = 256,
  parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  input  logic        err_clr,
  output logic        timeout_err
);

  localparam int WCW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WCW-1:0] WLAST = (TIMEOUT > 0) ? WCW'(TIMEOUT - 1) : '0;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]     state;
  logic           gnt;
  logic           last;
  logic [WCW-1:0] wcnt;

  logic        g_valid;
  logic [3:0]  g_wstrb;
  logic [31:0] g_addr;
  logic [31:0] g_wdata;
  logic        busy;
  logic        done;
  logic        tmo;
  logic        abandon;
  logic        rdy;
  logic [31:0] rdata;

  // Only the registered grant selects a master, so the idle master never reaches an output.
  always_comb begin
    g_valid = gnt ? m1_valid : m0_valid;
    g_wstrb = gnt ? m1_wstrb : m0_wstrb;
    g_addr  = gnt ? m1_addr  : m0_addr;
    g_wdata = gnt ? m1_wdata : m0_wdata;
  end

  assign busy    = (state == BUSY);
  assign abandon = busy && !g_valid;
  assign done    = busy && g_valid && s_ready;
  assign tmo     = (TIMEOUT != 0) && busy && g_valid && !s_ready && (wcnt == WLAST);
  assign rdy     = done || tmo;
  assign rdata   = tmo ? ERR_RDATA : s_rdata;

  assign s_valid = busy && g_valid && !tmo;
  assign s_wstrb = s_valid ? g_wstrb : 4'd0;
  assign s_addr  = s_valid ? g_addr  : 32'd0;
  assign s_wdata = s_valid ? g_wdata : 32'd0;

  assign m0_ready = rdy && !gnt;
  assign m1_ready = rdy && gnt;
  assign m0_rdata = m0_ready ? rdata : 32'd0;
  assign m1_rdata = m1_ready ? rdata : 32'd0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      gnt   <= 1'b0;
      last  <= 1'b1;
      wcnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_valid || m1_valid) begin
            state <= BUSY;
            gnt   <= (m0_valid && m1_valid) ? ~last : m1_valid;
            wcnt  <= '0;
          end
        end
        default: begin
          if (abandon) begin
            state <= IDLE;
          end else if (rdy) begin
            state <= IDLE;
            last  <= gnt;
          end else if (wcnt != {WCW{1'b1}}) begin
            wcnt <= wcnt + 1'b1;
          end
        end
      endcase
    end
  end

  // A timeout in the same cycle as err_clr leaves the flag set.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timeout_err <= 1'b0;
    end else if (tmo) begin
      timeout_err <= 1'b1;
    end else if (err_clr) begin
      timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_femto_mem_arbiter.sv
// Scoreboard bench for femto_mem_arbiter: the driver queues expected completions and a negedge monitor matches every ready pulse.
module tb_femto_mem_arbiter;

  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m0_valid, m1_valid;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid;
  logic [3:0]  s_wstrb;
  logic [31:0] s_addr, s_wdata;
  logic        s_ready;
  logic [31:0] s_rdata;
  logic        err_clr;
  logic        timeout_err;

  // Slave model: mode 0 never ready, 1 always ready, 2 ready one cycle after s_valid.
  int          mode = 2;
  logic        sr_q = 1'b0;
  logic [31:0] rd_val = 32'h0;

  typedef struct packed {logic m; logic [31:0] d;} exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  femto_mem_arbiter #(.TIMEOUT(8), .ERR_RDATA(ERR)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_wstrb(m0_wstrb), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_wstrb(m1_wstrb), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_wstrb(s_wstrb), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .err_clr(err_clr), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) sr_q <= (mode == 2) && s_valid && !sr_q;
  assign s_ready = (mode == 1) || ((mode == 2) && sr_q);
  assign s_rdata = rd_val;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every ready pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      if (!m0_ready) chk("m0_rdata_idle", m0_rdata, 32'd0);
      if (!m1_ready) chk("m1_rdata_idle", m1_rdata, 32'd0);
      if (m0_ready || m1_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ready", {30'd0, m1_ready, m0_ready}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("both_ready", {31'd0, m0_ready && m1_ready}, 32'd0);
          chk("ready_master", {31'd0, m1_ready}, {31'd0, e.m});
          chk("ready_rdata", m1_ready ? m1_rdata : m0_rdata, e.d);
        end
      end
    end
  end

  task automatic drive(input int m, input logic [3:0] ws, input logic [31:0] a, input logic [31:0] wd);
    if (m == 0) begin
      m0_valid = 1'b1; m0_wstrb = ws; m0_addr = a; m0_wdata = wd;
    end else begin
      m1_valid = 1'b1; m1_wstrb = ws; m1_addr = a; m1_wdata = wd;
    end
  endtask

  // Waits (bounded) for master m's ready, then releases its request after the edge.
  task automatic wait_done(input int m, inout int n);
    while (!(m == 0 ? m0_ready : m1_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    if (m == 0) m0_valid = 1'b0; else m1_valid = 1'b0;
  endtask

  task automatic req(input int m, input logic [3:0] ws, input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] er, input int lat);
    int n;
    exp_q.push_back({m[0], er});
    @(negedge clk);
    drive(m, ws, a, wd);
    @(negedge clk);
    n = 1;
    chk("s_valid_first", {31'd0, s_valid}, 32'd1);
    chk("s_addr", s_addr, a);
    chk("s_wstrb", {28'd0, s_wstrb}, {28'd0, ws});
    chk("s_wdata", s_wdata, wd);
    wait_done(m, n);
    chk("latency", n, lat);
  endtask

  initial begin
    int n;
    resetn = 1'b0; err_clr = 1'b0;
    m0_valid = 1'b0; m0_wstrb = 4'd0; m0_addr = 32'd0; m0_wdata = 32'd0;
    m1_valid = 1'b0; m1_wstrb = 4'd0; m1_addr = 32'd0; m1_wdata = 32'd0;
    mode = 1;
    rd_val = 32'h1234_5678;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s_valid", {31'd0, s_valid}, 32'd0);
    chk("rst_m0_ready", {31'd0, m0_ready}, 32'd0);
    chk("rst_m1_ready", {31'd0, m1_ready}, 32'd0);
    chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    chk("rst_s_addr", s_addr, 32'd0);
    chk("rst_m0_rdata", m0_rdata, 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    chk("idle_ignores_s_ready", {30'd0, m1_ready, m0_ready}, 32'd0);
    mode = 2;

    // Single read and write pass-through.
    req(0, 4'd0, 32'h0000_0010, 32'd0, 32'h1234_5678, 2);
    rd_val = 32'h0BAD_F00D;
    req(1, 4'b0101, 32'h0000_0100, 32'hAABB_CCDD, 32'h0BAD_F00D, 2);

    // Timeout, then clear, then a timeout coinciding with err_clr.
    mode = 0;
    req(0, 4'd0, 32'h0000_0020, 32'd0, ERR, 8);
    chk("timeout_err_set", {31'd0, timeout_err}, 32'd1);
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    chk("timeout_err_clr", {31'd0, timeout_err}, 32'd0);
    err_clr = 1'b1;
    req(1, 4'b1111, 32'h0000_0024, 32'h1111_2222, ERR, 8);
    err_clr = 1'b0;
    chk("set_beats_clr", {31'd0, timeout_err}, 32'd1);
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;

    // Contention from reset with a zero-wait slave: 0,1,0,1 with an idle cycle between.
    mode = 1;
    rd_val = 32'h5555_AAAA;
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    m0_addr = 32'h40; m1_addr = 32'h80; m0_wstrb = 4'd0; m1_wstrb = 4'd0;
    m0_valid = 1'b1; m1_valid = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back({i[0], 32'h5555_AAAA});
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk("cont_s_valid", {31'd0, s_valid}, {31'd0, c[0]});
      chk("cont_m0_ready", {31'd0, m0_ready}, {31'd0, (c % 4) == 1});
      chk("cont_m1_ready", {31'd0, m1_ready}, {31'd0, (c % 4) == 3});
      if (c[0]) chk("cont_s_addr", s_addr, ((c % 4) == 1) ? 32'h40 : 32'h80);
    end
    m0_valid = 1'b0; m1_valid = 1'b0;

    // Reset asserted mid-transfer; after release a tie goes to m0.
    mode = 2;
    rd_val = 32'hC0FF_EE00;
    req(0, 4'd0, 32'h0000_0030, 32'd0, 32'hC0FF_EE00, 2);
    mode = 0;
    @(negedge clk);
    drive(1, 4'd0, 32'h0000_0050, 32'd0);
    @(negedge clk);
    chk("mid_s_valid", {31'd0, s_valid}, 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("rst_async_s_valid", {31'd0, s_valid}, 32'd0);
    chk("rst_async_ready", {30'd0, m1_ready, m0_ready}, 32'd0);
    chk("rst_async_s_addr", s_addr, 32'd0);
    @(negedge clk);
    drive(0, 4'd0, 32'h0000_0060, 32'd0);
    mode = 2;
    exp_q.push_back({1'b0, 32'hC0FF_EE00});
    exp_q.push_back({1'b1, 32'hC0FF_EE00});
    resetn = 1'b1;
    @(negedge clk);
    chk("post_rst_tie_addr", s_addr, 32'h0000_0060);
    n = 1;
    wait_done(0, n);
    n = 0;
    wait_done(1, n);
    chk("post_rst_m1_done", {31'd0, n < 50}, 32'd1);

    // Abandon: m1 drops its request while granted; the pending m0 wins the next tie.
    mode = 0;
    @(negedge clk);
    drive(1, 4'd0, 32'h0000_0070, 32'd0);
    @(negedge clk);
    drive(0, 4'd0, 32'h0000_0074, 32'd0);
    #1;
    chk("abn_s_addr", s_addr, 32'h0000_0070);
    @(negedge clk);
    m1_valid = 1'b0;
    #1;
    chk("abn_s_valid_drop", {31'd0, s_valid}, 32'd0);
    chk("abn_no_ready", {30'd0, m1_ready, m0_ready}, 32'd0);
    mode = 2;
    @(negedge clk);
    chk("abn_idle", {31'd0, s_valid}, 32'd0);
    m1_valid = 1'b1;
    exp_q.push_back({1'b0, 32'hC0FF_EE00});
    exp_q.push_back({1'b1, 32'hC0FF_EE00});
    @(negedge clk);
    chk("abn_next_addr", s_addr, 32'h0000_0074);
    n = 1;
    wait_done(0, n);
    chk("abn_m0_latency", n, 2);
    n = 0;
    wait_done(1, n);

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/femto_mem_arbiter.md
# femto_mem_arbiter

Two-master arbiter for the PicoRV32 native memory bus in the FemtoSoC. It shares one slave port (the on-chip RAM plus iomem decode) between the CPU (master 0) and a secondary requester such as a firmware loader or DMA engine (master 1). Ties are broken round-robin, and the grant is held for a whole transfer. A per-transfer timeout guarantees that a hung slave never stalls a master indefinitely.

## Interface
Parameters:
- TIMEOUT, 256: cycles a granted transfer may wait for s_ready; 0 disables the timeout.
- ERR_RDATA, 32'h DEAD_BEEF: read data returned on a timed-out transfer.

Ports:
- clk, in, 1: single clock; all state on rising edge.
- resetn, in, 1: asynchronous, active-low reset.
- m0_valid / m1_valid, in, 1: master request; held until the matching ready.
- m0_wstrb / m1_wstrb, in, 4: byte write strobes; 0 means read.
- m0_addr / m1_addr, in, 32: byte address.
- m0_wdata / m1_wdata, in, 32: write data.
- m0_ready / m1_ready, out, 1: one-cycle completion strobe.
- m0_rdata / m1_rdata, out, 32: read data, valid when the matching ready is 1.
- s_valid, out, 1: request to slave.
- s_wstrb, s_addr, s_wdata, out, 4/32/32: muxed from the granted master.
- s_ready, in, 1: slave completion.
- s_rdata, in, 32: slave read data.
- err_clr, in, 1: clears timeout_err.
- timeout_err, out, 1: sticky flag, set on any timeout.

## Operation
- States: IDLE, BUSY. The registered grant `gnt` (0/1) is meaningful only in BUSY.
- IDLE:
  - If exactly one mN_valid is 1, capture gnt=N and go to BUSY.
  - If both are 1, grant the master not equal to `last`.
  - Otherwise stay in IDLE.
- BUSY:
  - s_valid = m[gnt]_valid. s_wstrb, s_addr and s_wdata are muxed from m[gnt]. The non-granted master sees ready=0.
  - Completion: when s_ready=1 while s_valid=1, assert m[gnt]_ready=1 with m[gnt]_rdata=s_rdata in that cycle (combinational pass-through). Then set last<=gnt and go to IDLE.
  - Timeout: wait counter `wcnt` clears on entry to BUSY and increments each BUSY cycle without s_ready. With TIMEOUT≠0, in the cycle wcnt==TIMEOUT-1 and s_ready=0:
    - force s_valid=0;
    - assert m[gnt]_ready=1 with m[gnt]_rdata=ERR_RDATA (writes are discarded);
    - set timeout_err, set last<=gnt, go to IDLE.
  - Abandon: if m[gnt]_valid drops to 0 without ready, go to IDLE with no ready pulse; `last` is unchanged.
- m[N]_rdata is 0 whenever m[N]_ready=0.
- wcnt width is clog2(TIMEOUT+1) and saturates; it never wraps.
- timeout_err: err_clr clears it. If a set and a clear occur in the same cycle, the set wins.
- The slave port's s_ready is ignored in IDLE.

## Timing
- Reset values: state=IDLE, gnt=0, last=1 (so m0 wins the first tie), wcnt=0, timeout_err=0. All outputs are 0: s_valid, s_*, m*_ready, m*_rdata.
- Arbitration latency: request seen in cycle T produces s_valid in T+1.
- Minimum transfer: slave ready in T+1 gives mN_ready in T+1, so two cycles from valid to ready.
- Back-to-back: the cycle after a completion is always IDLE. A waiting master is granted there and gets s_valid one cycle later.
  - With continuous requests from both masters, grants strictly alternate 0,1,0,1.
- A timeout completes exactly TIMEOUT cycles after s_valid first rose.
- Reset asserted mid-BUSY: all outputs go to 0 immediately (asynchronous). No ready pulse is issued, and on release the arbiter restarts in IDLE with last=1.
- Outputs are combinational from state and the granted master's and slave's signals. There are no combinational paths from the non-granted master to any output.

## Test plan
- Single read: m0 reads 0x0000_0010. Slave ready one cycle after s_valid with rdata 0x1234_5678 -> m0_ready for one cycle with m0_rdata 0x1234_5678; m1_ready stays 0.
- Write pass-through: m1 writes wstrb=4'b0101, addr 0x0000_0100, wdata 0xAABB_CCDD -> identical values on s_*; m1_ready aligned to s_ready.
- Contention: both valid from reset, slave zero-wait -> grant order m0, m1, m0, m1. Each master gets ready exactly once per request, with one IDLE cycle between transfers.
- Timeout: TIMEOUT=8, slave never ready -> m0_ready 8 cycles after s_valid rose, with rdata 0xDEAD_BEEF. timeout_err=1 until err_clr. A set and clear in the same cycle leaves timeout_err=1.
- Reset mid-transfer: assert resetn=0 in BUSY -> s_valid and all readys go to 0 in the same cycle. After release, a tie grants m0 first.
- Abandon: m1 granted, m1_valid drops before s_ready -> state returns to IDLE with no m1_ready. A pending m0 is granted next, since `last` is unchanged.
